// File: rtl/s_axi_regfile_if.sv
// AXI4-Lite slave bus bundle for the s_axi_regfile register block.
// The master modport drives requests; the slave modport answers them.
interface s_axi_regfile_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;

  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;

  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;

  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;

  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/s_axi_regfile.sv
// AXI4-Lite slave with NUM_REGS read/write 32-bit registers.
// AW and W are captured independently into hold registers; a write commits one
// cycle after both holds are full, so at most one write is ever outstanding.
// Reads complete with one cycle of latency and run alongside writes.
// Word index is ADDR[4:2]; indices at or above NUM_REGS answer SLVERR.
module s_axi_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  s_axi_regfile_if.slave                         s_axi,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out
);

  localparam int         NUM_LANES   = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                          aw_held, w_held, wr_go;
  logic [2:0]                    aw_idx_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [NUM_LANES-1:0]          wstrb_q;
  logic                          awready_q, wready_q, bvalid_q;
  logic [1:0]                    bresp_q;

  logic                          arready_q, rvalid_q;
  logic [1:0]                    rresp_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

  logic                          aw_hs, w_hs, ar_hs;
  logic                          aw_held_d, w_held_d, bvalid_d, rvalid_d;
  logic                          wr_in_range, rd_in_range;
  logic [2:0]                    ar_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;

  // Handshakes, next-state of holds/valids, and read-address decode
  always_comb begin
    aw_hs       = s_axi.S_AXI_AWVALID & awready_q;
    w_hs        = s_axi.S_AXI_WVALID & wready_q;
    ar_hs       = s_axi.S_AXI_ARVALID & arready_q;
    wr_in_range = int'(aw_idx_q) < NUM_REGS;
    ar_idx      = s_axi.S_AXI_ARADDR[4:2];
    rd_in_range = int'(ar_idx) < NUM_REGS;
    aw_held_d   = wr_go ? 1'b0 : (aw_held | aw_hs);
    w_held_d    = wr_go ? 1'b0 : (w_held | w_hs);
    bvalid_d    = wr_go | (bvalid_q & ~s_axi.S_AXI_BREADY);
    rvalid_d    = ar_hs | (rvalid_q & ~s_axi.S_AXI_RREADY);
    rd_word     = '0;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (ar_idx == 3'(n)) rd_word = regs[n];
    end
  end

  // Write path: capture AW/W, commit byte lanes, hold the B response
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      wr_go     <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      for (int n = 0; n < NUM_REGS; n++) regs[n] <= '0;
    end else begin
      aw_held   <= aw_held_d;
      w_held    <= w_held_d;
      bvalid_q  <= bvalid_d;
      awready_q <= ~aw_held_d & ~bvalid_d;
      wready_q  <= ~w_held_d & ~bvalid_d;
      // wr_go marks the single commit cycle once both holds have been full
      wr_go     <= aw_held & w_held & ~wr_go & ~bvalid_q;
      if (aw_hs) aw_idx_q <= s_axi.S_AXI_AWADDR[4:2];
      if (w_hs) begin
        wdata_q <= s_axi.S_AXI_WDATA;
        wstrb_q <= s_axi.S_AXI_WSTRB;
      end
      if (wr_go) begin
        bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
        for (int n = 0; n < NUM_REGS; n++) begin
          for (int k = 0; k < NUM_LANES; k++) begin
            if (wr_in_range && aw_idx_q == 3'(n) && wstrb_q[k])
              regs[n][8*k +: 8] <= wdata_q[8*k +: 8];
          end
        end
      end
    end
  end

  // Read path: sample the addressed register on AR handshake, hold until RREADY
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      rvalid_q  <= rvalid_d;
      arready_q <= ~rvalid_d;
      if (ar_hs) begin
        rdata_q <= rd_in_range ? rd_word : '0;
        rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH] = regs[g];
  end

  // Protection bits and byte-offset address bits carry no meaning here
  logic unused_ok;
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_s_axi_regfile.sv
// Directed bench for s_axi_regfile: write/read sequences with hand-computed
// expected register, response and handshake values.
module tb_s_axi_regfile;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] reg_out;

  int checks   = 0;
  int failures = 0;

  s_axi_regfile_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) axi ();

  s_axi_regfile #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .NUM_REGS(4)
  ) dut (
    .ACLK    (clk),
    .ARESET  (rst),
    .s_axi   (axi),
    .reg_out (reg_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write with W leading AW by w_lead cycles; BREADY withheld for hold_b cycles.
  task automatic do_write(input string tag, input logic [4:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int w_lead, input int hold_b,
                          output logic [1:0] resp, output int lat, output int stray);
    int cyc;
    bit aw_done, w_done, aw_fire, w_fire;
    stray = 0;
    lat   = -1;
    resp  = 2'b11;
    @(negedge clk);
    axi.S_AXI_AWADDR = addr;
    axi.S_AXI_WDATA  = data;
    axi.S_AXI_WSTRB  = strb;
    axi.S_AXI_WVALID = 1'b1;
    cyc = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      if (cyc == w_lead && !aw_done) axi.S_AXI_AWVALID = 1'b1;
      if (axi.S_AXI_BVALID) stray++;
      aw_fire = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      w_fire  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      @(posedge clk); #1;
      if (aw_fire) begin axi.S_AXI_AWVALID = 1'b0; aw_done = 1; end
      if (w_fire)  begin axi.S_AXI_WVALID  = 1'b0; w_done  = 1; end
      if (!(aw_done && w_done)) @(negedge clk);
      cyc++;
    end
    if (!(aw_done && w_done)) begin
      check({tag, " aw/w handshake timeout"}, 0, 1);
      axi.S_AXI_AWVALID = 1'b0;
      axi.S_AXI_WVALID  = 1'b0;
      return;
    end
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (axi.S_AXI_BVALID) break;
    end
    if (!axi.S_AXI_BVALID) begin
      check({tag, " bvalid timeout"}, 0, 1);
      return;
    end
    resp = axi.S_AXI_BRESP;
    for (int i = 0; i < hold_b; i++) begin
      @(negedge clk);
      check({tag, " b hold {bvalid,bresp,awready,wready}"},
            {axi.S_AXI_BVALID, axi.S_AXI_BRESP, axi.S_AXI_AWREADY, axi.S_AXI_WREADY},
            {1'b1, resp, 1'b0, 1'b0});
    end
    axi.S_AXI_BREADY = 1'b1;
    @(posedge clk); #1;
    axi.S_AXI_BREADY = 1'b0;
    @(negedge clk);
    check({tag, " after b {bvalid,awready,wready}"},
          {axi.S_AXI_BVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, 3'b011);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (axi.S_AXI_BVALID) stray++;
    end
  endtask

  task automatic do_read(input string tag, input logic [4:0] addr,
                         output logic [31:0] data, output logic [1:0] resp);
    int n;
    data = '0;
    resp = 2'b11;
    @(negedge clk);
    axi.S_AXI_ARADDR  = addr;
    axi.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!axi.S_AXI_ARREADY && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!axi.S_AXI_ARREADY) begin
      check({tag, " arready timeout"}, 0, 1);
      axi.S_AXI_ARVALID = 1'b0;
      return;
    end
    @(posedge clk); #1;
    axi.S_AXI_ARVALID = 1'b0;
    check({tag, " rvalid one cycle after ar"}, axi.S_AXI_RVALID, 1);
    data = axi.S_AXI_RDATA;
    resp = axi.S_AXI_RRESP;
    axi.S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    axi.S_AXI_RREADY = 1'b0;
    @(negedge clk);
    check({tag, " after r {rvalid,arready}"}, {axi.S_AXI_RVALID, axi.S_AXI_ARREADY}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int          lat, stray, n;

    axi.S_AXI_AWADDR  = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA   = '0; axi.S_AXI_WSTRB  = '0; axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_BREADY  = 1'b0;
    axi.S_AXI_ARADDR  = '0; axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset {awready,wready,arready,bvalid,rvalid}",
          {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY,
           axi.S_AXI_BVALID, axi.S_AXI_RVALID}, 5'b0);
    check("reset {bresp,rresp,rdata}",
          {axi.S_AXI_BRESP, axi.S_AXI_RRESP, axi.S_AXI_RDATA}, 36'h0);
    check("reset reg_out", reg_out, 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready before first released edge",
          {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 3'b000);
    @(negedge clk);
    check("ready after first released edge",
          {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 3'b111);

    // Basic write/read of all four registers
    for (int i = 0; i < 4; i++) begin
      do_write($sformatf("wr%0d", i), 5'(i * 4), 32'(i + 1), 4'hF, 0, 0, resp, lat, stray);
      check($sformatf("wr%0d bresp", i), resp, 2'b00);
      if (i == 0) check("wr0 latency", lat, 2);
    end
    check("reg_out after 4 writes", reg_out,
          {32'h4, 32'h3, 32'h2, 32'h1});
    for (int i = 0; i < 4; i++) begin
      do_read($sformatf("rd%0d", i), 5'(i * 4), rd, resp);
      check($sformatf("rd%0d rdata", i), rd, 32'(i + 1));
      check($sformatf("rd%0d rresp", i), resp, 2'b00);
    end

    // W three cycles ahead of AW, partial strobe
    do_write("init r0", 5'h00, 32'h11223344, 4'hF, 0, 0, resp, lat, stray);
    check("init r0 bresp", resp, 2'b00);
    do_write("wfirst", 5'h00, 32'hAABBCCDD, 4'b0011, 3, 0, resp, lat, stray);
    check("wfirst bresp", resp, 2'b00);
    check("wfirst stray bvalid", stray, 0);
    check("wfirst r0", reg_out[31:0], 32'h1122CCDD);
    do_read("wfirst rd", 5'h00, rd, resp);
    check("wfirst rd rdata", rd, 32'h1122CCDD);

    // BREADY withheld, then a second write
    do_write("bhold", 5'h08, 32'h00000099, 4'hF, 0, 5, resp, lat, stray);
    check("bhold bresp", resp, 2'b00);
    do_write("after bhold", 5'h0C, 32'h00000077, 4'hF, 0, 0, resp, lat, stray);
    check("after bhold bresp", resp, 2'b00);
    check("after bhold reg_out", reg_out,
          {32'h77, 32'h99, 32'h2, 32'h1122CCDD});

    // Upper-lane strobe and ignored byte-offset bits
    do_write("strb hi", 5'h0B, 32'h12345678, 4'b1100, 0, 0, resp, lat, stray);
    check("strb hi r2", reg_out[95:64], 32'h12340099);
    do_read("unaligned rd", 5'h09, rd, resp);
    check("unaligned rd rdata", rd, 32'h12340099);

    // Out-of-range accesses
    do_write("oor 0x14", 5'h14, 32'h0000DEAD, 4'hF, 0, 0, resp, lat, stray);
    check("oor 0x14 bresp", resp, 2'b10);
    do_write("oor 0x10", 5'h10, 32'h0000BEEF, 4'hF, 0, 0, resp, lat, stray);
    check("oor 0x10 bresp", resp, 2'b10);
    do_read("oor rd", 5'h14, rd, resp);
    check("oor rd rdata", rd, 32'h0);
    check("oor rd rresp", resp, 2'b10);
    check("oor reg_out unchanged", reg_out,
          {32'h77, 32'h12340099, 32'h2, 32'h1122CCDD});

    // Read captured on the same edge as a write commit to the same register
    @(negedge clk);
    check("collide ready", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, 2'b11);
    axi.S_AXI_AWADDR = 5'h04; axi.S_AXI_WDATA = 32'h55; axi.S_AXI_WSTRB = 4'hF;
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
    @(posedge clk); #1;
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    axi.S_AXI_ARADDR = 5'h04; axi.S_AXI_ARVALID = 1'b1;
    @(posedge clk); #1;
    axi.S_AXI_ARVALID = 1'b0;
    check("collide {rvalid,bvalid}", {axi.S_AXI_RVALID, axi.S_AXI_BVALID}, 2'b11);
    check("collide rdata old", axi.S_AXI_RDATA, 32'h2);
    check("collide r1 new", reg_out[63:32], 32'h55);
    axi.S_AXI_BREADY = 1'b1; axi.S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    axi.S_AXI_BREADY = 1'b0; axi.S_AXI_RREADY = 1'b0;
    do_read("collide reread", 5'h04, rd, resp);
    check("collide reread rdata", rd, 32'h55);

    // Reset while both a B and an R response are pending
    @(negedge clk);
    axi.S_AXI_AWADDR = 5'h08; axi.S_AXI_WDATA = 32'hABC; axi.S_AXI_WSTRB = 4'hF;
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
    @(posedge clk); #1;
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
    n = 0;
    while (!axi.S_AXI_BVALID && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("pre-reset bvalid", axi.S_AXI_BVALID, 1);
    @(negedge clk);
    axi.S_AXI_ARADDR = 5'h00; axi.S_AXI_ARVALID = 1'b1;
    @(posedge clk); #1;
    axi.S_AXI_ARVALID = 1'b0;
    @(negedge clk);
    check("pre-reset {bvalid,rvalid}", {axi.S_AXI_BVALID, axi.S_AXI_RVALID}, 2'b11);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid reset outputs {bvalid,rvalid,awready,wready,arready}",
          {axi.S_AXI_BVALID, axi.S_AXI_RVALID, axi.S_AXI_AWREADY,
           axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 5'b0);
    check("mid reset reg_out", reg_out, 128'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_read($sformatf("post rst rd%0d", i), 5'(i * 4), rd, resp);
      check($sformatf("post rst rd%0d rdata", i), rd, 32'h0);
    end
    do_write("post rst wr", 5'h04, 32'h00001234, 4'hF, 0, 0, resp, lat, stray);
    check("post rst wr bresp", resp, 2'b00);
    check("post rst reg_out", reg_out, {32'h0, 32'h0, 32'h1234, 32'h0});
    do_read("post rst rd back", 5'h04, rd, resp);
    check("post rst rd back rdata", rd, 32'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/s_axi_regfile.md
S_AXI_REGFILE -- requirements
Module: s_axi_regfile

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 5, byte-address width.
REQ-003 Parameter NUM_REGS, default 4, number of 32-bit read/write registers at byte offsets 0x00, 0x04, 0x08, 0x0C.
REQ-004 ACLK input 1: the only clock; all logic samples on its rising edge.
REQ-005 ARESET input 1: synchronous, active-high reset.
REQ-006 S_AXI_AWADDR input 5, S_AXI_AWPROT input 3 (ignored), S_AXI_AWVALID input 1, S_AXI_AWREADY output 1: write-address channel.
REQ-007 S_AXI_WDATA input 32, S_AXI_WSTRB input 4, S_AXI_WVALID input 1, S_AXI_WREADY output 1: write-data channel.
REQ-008 S_AXI_BRESP output 2, S_AXI_BVALID output 1, S_AXI_BREADY input 1: write-response channel.
REQ-009 S_AXI_ARADDR input 5, S_AXI_ARPROT input 3 (ignored), S_AXI_ARVALID input 1, S_AXI_ARREADY output 1: read-address channel.
REQ-010 S_AXI_RDATA output 32, S_AXI_RRESP output 2, S_AXI_RVALID output 1, S_AXI_RREADY input 1: read-data channel.
REQ-011 reg_out output NUM_REGS*32: live register contents, register n in bits [32n+31:32n].

Function
REQ-012 Decode: word index = ADDR[4:2]; ADDR[1:0] ignored; index < NUM_REGS is in range; otherwise out of range.
REQ-013 Write path, independent AW and W capture: AWREADY = 1 while no address is held and BVALID = 0; WREADY = 1 while no data is held and BVALID = 0.
REQ-014 A handshake (VALID & READY) latches AWADDR or WDATA/WSTRB; AW and W may arrive in either order or in the same cycle.
REQ-015 In the cycle after both address and data are held: update the register by byte lanes where WSTRB[k] = 1, clear both holds, set BVALID = 1.
REQ-016 BRESP = 2'b00 (OKAY) for an in-range write; 2'b10 (SLVERR) for an out-of-range write, with no register modified.
REQ-017 BVALID holds with BRESP stable until BREADY = 1; it drops in the cycle after the handshake; AW/W acceptance resumes only once BVALID = 0 (at most one outstanding write).
REQ-018 Minimum write latency with AW and W in the same cycle and BREADY = 1: BVALID is asserted 2 cycles after the handshake edge.
REQ-019 Read path: ARREADY = 1 while RVALID = 0; on an AR handshake, RDATA is loaded with the addressed register and RVALID is set at the same edge (1-cycle latency).
REQ-020 RRESP = 00 and RDATA = register value for an in-range read; RRESP = 10 and RDATA = 0 for an out-of-range read.
REQ-021 RVALID holds with RDATA/RRESP stable until RREADY = 1; it drops the cycle after the handshake, so back-to-back reads run at one read every 2 cycles.
REQ-022 Read and write paths run concurrently. A read captured in the same cycle as a write commit to the same register returns the pre-write value.
REQ-023 Outputs are registered; no combinational path from any input to any output.

Reset
REQ-024 While ARESET = 1 at a clock edge: all registers = 0; AWREADY, WREADY, ARREADY, BVALID, RVALID = 0; BRESP, RRESP, RDATA = 0; both write holds cleared.
REQ-025 The first edge with ARESET = 0 enables READY outputs on the next cycle.
REQ-026 Reset asserted mid-transaction discards held AW/W and pending B/R responses without completing them.

Verification
REQ-027 Write 0x1, 0x2, 0x3, 0x4 to 0x00, 0x04, 0x08, 0x0C, then read all four -> RDATA 0x1..0x4, all BRESP/RRESP = 00.
REQ-028 W presented 3 cycles before AW, WSTRB = 4'b0011, data 0xAABBCCDD on register 0 = 0x11223344 -> register becomes 0x1122CCDD, exactly one BVALID pulse.
REQ-029 BREADY held 0 for 5 cycles -> BVALID and BRESP remain stable; AWREADY = WREADY = 0 throughout; a second write completes after release.
REQ-030 Write to and read from 0x14 -> BRESP = 10, RRESP = 10, RDATA = 0, registers 0-3 unchanged.
REQ-031 Same-cycle AR to 0x04 and write commit of 0x55 to 0x04 (old value 0x2) -> RDATA = 0x2; a subsequent read returns 0x55.
REQ-032 ARESET pulsed while BVALID = 1 and RVALID = 1 -> both drop at the reset edge, all registers read 0 afterwards, and the next write completes normally.
